// File: rtl/core_mem_pkg.sv
// Shared types and constants for the core memory arbiter.
package core_mem_pkg;

   localparam int unsigned STATE_W     = 4;
   localparam int unsigned MEM_LAT_MAX = 4;
   localparam int unsigned CNT_W       = $clog2(MEM_LAT_MAX);

   localparam logic SRC_I = 1'b0;
   localparam logic SRC_D = 1'b1;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 4'b0001,
      ST_ACCESS = 4'b0010,
      ST_WAIT   = 4'b0100,
      ST_RESP   = 4'b1000
   } state_e;

endpackage

// File: rtl/core_mem_pick.sv
// Winner selection between fetch and data requests.
// CORE_MEM_ARB_RR_EN selects round-robin on conflict; otherwise data has fixed priority.
module core_mem_pick
   import core_mem_pkg::*;
(
   input  logic CLK,
   input  logic RST,
   input  logic i_req,
   input  logic d_req,
   input  logic take,
   output logic src_c
);

`ifdef CORE_MEM_ARB_RR_EN
   logic last_q;

   // Remembers the most recent winner; starts at I so the first conflict goes to D.
   always_ff @(posedge CLK) begin
      if (RST) begin
         last_q <= SRC_I;
      end else if (take) begin
         last_q <= src_c;
      end
   end

   always_comb begin
      src_c = SRC_I;
      if (i_req && d_req) begin
         src_c = (last_q == SRC_I) ? SRC_D : SRC_I;
      end else if (d_req) begin
         src_c = SRC_D;
      end
   end
`else
   logic unused_c;
   assign unused_c = ^{CLK, RST, i_req, take};

   always_comb begin
      src_c = d_req ? SRC_D : SRC_I;
   end
`endif

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one single-port synchronous memory between fetch and load/store ports,
// one transaction outstanding. Round-robin conflict resolution under CORE_MEM_ARB_RR_EN.
module core_mem_arbiter
   import core_mem_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 1
)
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              I_REQ,
   input  logic [ADDR_W-1:0] I_ADDR,
   output logic              I_GNT,
   output logic              I_VALID,
   output logic [DATA_W-1:0] I_RDATA,
   input  logic              D_REQ,
   input  logic              D_WE,
   input  logic [ADDR_W-1:0] D_ADDR,
   input  logic [DATA_W-1:0] D_WDATA,
   output logic              D_GNT,
   output logic              D_VALID,
   output logic [DATA_W-1:0] D_RDATA,
   output logic [ADDR_W-1:0] M_ADDR,
   output logic [DATA_W-1:0] M_WDATA,
   output logic              M_RE,
   output logic              M_WE,
   input  logic [DATA_W-1:0] M_RDATA
);

   if ((MEM_LAT < 1) || (MEM_LAT > MEM_LAT_MAX)) begin : g_lat_chk
      $error("core_mem_arbiter: MEM_LAT must be within 1..4");
   end

   state_e            state_q, state_nxt;
   logic [CNT_W-1:0]  cnt_q, cnt_nxt;
   logic              src_q, src_nxt;
   logic              we_q, we_nxt;
   logic [ADDR_W-1:0] addr_q, addr_nxt;
   logic [DATA_W-1:0] wdata_q, wdata_nxt;
   logic              i_gnt_q, i_gnt_nxt, d_gnt_q, d_gnt_nxt;
   logic              i_valid_q, i_valid_nxt, d_valid_q, d_valid_nxt;
   logic              m_re_q, m_re_nxt, m_we_q, m_we_nxt;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_nxt, d_rdata_q, d_rdata_nxt;
   logic              take_c;
   logic              pick_src_c;

   core_mem_pick u_pick (
      .CLK   (CLK),
      .RST   (RST),
      .i_req (I_REQ),
      .d_req (D_REQ),
      .take  (take_c),
      .src_c (pick_src_c)
   );

   // Next-state and next-output logic; strobes are precomputed so they register into their cycle.
   always_comb begin
      state_nxt   = state_q;
      cnt_nxt     = cnt_q;
      src_nxt     = src_q;
      we_nxt      = we_q;
      addr_nxt    = addr_q;
      wdata_nxt   = wdata_q;
      i_gnt_nxt   = 1'b0;
      d_gnt_nxt   = 1'b0;
      i_valid_nxt = 1'b0;
      d_valid_nxt = 1'b0;
      m_re_nxt    = 1'b0;
      m_we_nxt    = 1'b0;
      i_rdata_nxt = i_rdata_q;
      d_rdata_nxt = d_rdata_q;
      take_c      = 1'b0;

      case (state_q)
         ST_IDLE, ST_RESP: begin
            if (I_REQ || D_REQ) begin
               take_c    = 1'b1;
               src_nxt   = pick_src_c;
               state_nxt = ST_ACCESS;
               if (pick_src_c == SRC_D) begin
                  we_nxt    = D_WE;
                  addr_nxt  = D_ADDR;
                  wdata_nxt = D_WDATA;
                  d_gnt_nxt = 1'b1;
                  m_we_nxt  = D_WE;
                  m_re_nxt  = !D_WE;
               end else begin
                  we_nxt    = 1'b0;
                  addr_nxt  = I_ADDR;
                  wdata_nxt = '0;
                  i_gnt_nxt = 1'b1;
                  m_re_nxt  = 1'b1;
               end
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            cnt_nxt   = CNT_W'(MEM_LAT - 1);
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_nxt = ST_RESP;
               if (src_q == SRC_D) begin
                  d_valid_nxt = 1'b1;
                  d_rdata_nxt = we_q ? '0 : M_RDATA;
               end else begin
                  i_valid_nxt = 1'b1;
                  i_rdata_nxt = M_RDATA;
               end
            end else begin
               cnt_nxt = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         src_q     <= SRC_I;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         i_gnt_q   <= 1'b0;
         d_gnt_q   <= 1'b0;
         i_valid_q <= 1'b0;
         d_valid_q <= 1'b0;
         m_re_q    <= 1'b0;
         m_we_q    <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_nxt;
         cnt_q     <= cnt_nxt;
         src_q     <= src_nxt;
         we_q      <= we_nxt;
         addr_q    <= addr_nxt;
         wdata_q   <= wdata_nxt;
         i_gnt_q   <= i_gnt_nxt;
         d_gnt_q   <= d_gnt_nxt;
         i_valid_q <= i_valid_nxt;
         d_valid_q <= d_valid_nxt;
         m_re_q    <= m_re_nxt;
         m_we_q    <= m_we_nxt;
         i_rdata_q <= i_rdata_nxt;
         d_rdata_q <= d_rdata_nxt;
      end
   end

   assign I_GNT   = i_gnt_q;
   assign D_GNT   = d_gnt_q;
   assign I_VALID = i_valid_q;
   assign D_VALID = d_valid_q;
   assign I_RDATA = i_rdata_q;
   assign D_RDATA = d_rdata_q;
   assign M_ADDR  = addr_q;
   assign M_WDATA = wdata_q;
   assign M_RE    = m_re_q;
   assign M_WE    = m_we_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed and randomized bench for core_mem_arbiter with a transaction-level reference.
module tb_core_mem_arbiter;

   localparam int LAT = 3;

   logic        clk;
   logic        rst;
   logic        mem_load;
   logic        i_req, d_req, d_we;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic        I_GNT, I_VALID, D_GNT, D_VALID, M_RE, M_WE;
   logic [31:0] I_RDATA, D_RDATA, M_ADDR, M_WDATA, m_rdata;

   core_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
      .CLK(clk), .RST(rst),
      .I_REQ(i_req), .I_ADDR(i_addr), .I_GNT(I_GNT), .I_VALID(I_VALID), .I_RDATA(I_RDATA),
      .D_REQ(d_req), .D_WE(d_we), .D_ADDR(d_addr), .D_WDATA(d_wdata),
      .D_GNT(D_GNT), .D_VALID(D_VALID), .D_RDATA(D_RDATA),
      .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_RE(M_RE), .M_WE(M_WE), .M_RDATA(m_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      return (i == 16) ? 32'h0050_0093 : 32'hC0DE_0000 + 32'(i) * 32'h0001_0003;
   endfunction

   // Memory macro: synchronous, read data appears LAT cycles after the read strobe.
   logic [31:0] mem  [128];
   logic [31:0] pipe [LAT];
   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < 128; i++) mem[i] <= init_word(i);
      end else if (M_WE) begin
         mem[M_ADDR[6:0]] <= M_WDATA;
      end
      pipe[0] <= M_RE ? mem[M_ADDR[6:0]] : 32'hBAD0_BAD0;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
   end
   assign m_rdata = pipe[LAT-1];

   // Reference state
   logic [31:0] ref_mem [128];
   int          cyc, gnt_at, val_at, next_ok;
   logic        m_src, m_we, rr_last;
   logic [31:0] m_addr, m_wdata, m_load, exp_i_rdata, exp_d_rdata;
   int          mode;
   int          n_chk, n_pass;
   int          we_cnt, strobe_cnt, i_val_cyc;
   logic        glog [$];
   int          dvals [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Returns 1 for D, 0 for I.
   function automatic logic model_pick(input logic ir, input logic dr);
      if (!dr) return 1'b0;
      if (!ir) return 1'b1;
`ifdef CORE_MEM_ARB_RR_EN
      return ~rr_last;
`else
      return 1'b1;
`endif
   endfunction

   task automatic new_i();
      i_req  = 1'b1;
      i_addr = $urandom_range(0, 127);
   endtask

   task automatic new_d();
      d_req   = 1'b1;
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = $urandom_range(0, 127);
      d_wdata = $urandom;
   endtask

   // One clock: predict, advance, compare, then let the requesters react.
   task automatic tick();
      int          e;
      logic        g, v, gi, gd;
      logic [5:0]  exp_v;
      e = cyc + 1;
      if (rst) begin
         gnt_at = -1; val_at = -1; next_ok = e + 1;
         exp_i_rdata = '0; exp_d_rdata = '0; rr_last = 1'b0;
      end else if (e >= next_ok && (i_req || d_req)) begin
         m_src   = model_pick(i_req, d_req);
         m_we    = m_src ? d_we : 1'b0;
         m_addr  = m_src ? d_addr : i_addr;
         m_wdata = m_src ? d_wdata : 32'h0;
         if (m_we) ref_mem[m_addr[6:0]] = m_wdata;
         m_load  = m_we ? 32'h0 : ref_mem[m_addr[6:0]];
         gnt_at  = e;
         val_at  = e + 1 + LAT;
         next_ok = e + LAT + 2;
         rr_last = m_src;
      end
      @(posedge clk);
      cyc = e;
      #1;
      g = (cyc == gnt_at);
      v = (cyc == val_at);
      if (v) begin
         if (m_src) exp_d_rdata = m_load;
         else       exp_i_rdata = m_load;
      end
      exp_v = {g && !m_src, g && m_src, v && !m_src, v && m_src, g && !m_we, g && m_we};
      chk("strobes", {58'h0, I_GNT, D_GNT, I_VALID, D_VALID, M_RE, M_WE}, {58'h0, exp_v});
      chk("i_rdata", {32'h0, I_RDATA}, {32'h0, exp_i_rdata});
      chk("d_rdata", {32'h0, D_RDATA}, {32'h0, exp_d_rdata});
      if (g) begin
         chk("m_addr",  {32'h0, M_ADDR},  {32'h0, m_addr});
         chk("m_wdata", {32'h0, M_WDATA}, {32'h0, m_wdata});
      end
      if (I_GNT || D_GNT) glog.push_back(D_GNT);
      if (D_VALID) dvals.push_back(cyc);
      if (I_VALID) i_val_cyc = cyc;
      if (M_WE) we_cnt++;
      if (I_GNT || D_GNT || I_VALID || D_VALID || M_RE || M_WE) strobe_cnt++;

      gi = g && !m_src;
      gd = g && m_src;
      if (gi) begin
         if (mode == 1) i_addr = $urandom_range(0, 127);
         else if (mode == 2 && $urandom_range(0, 1) == 1) new_i();
         else i_req = 1'b0;
      end else if (mode == 2 && !i_req && $urandom_range(0, 2) == 0) begin
         new_i();
      end
      if (gd) begin
         if (mode == 1) d_addr = $urandom_range(0, 127);
         else if (mode == 2 && $urandom_range(0, 1) == 1) new_d();
         else d_req = 1'b0;
      end else if (mode == 2 && !d_req && $urandom_range(0, 2) == 0) begin
         new_d();
      end
   endtask

   initial begin
      int   samp;
      logic [3:0] exp_order;
      n_chk = 0; n_pass = 0; cyc = 0; gnt_at = -1; val_at = -1; next_ok = 0;
      m_src = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_load = '0;
      exp_i_rdata = '0; exp_d_rdata = '0; rr_last = 1'b0;
      mode = 0; we_cnt = 0; strobe_cnt = 0; i_val_cyc = -1;
      for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
      rst = 1'b1; mem_load = 1'b1;
      i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      repeat (3) tick();
      chk("reset_m_addr",  {32'h0, M_ADDR},  64'h0);
      chk("reset_m_wdata", {32'h0, M_WDATA}, 64'h0);
      rst = 1'b0; mem_load = 1'b0;
      tick();

      // Conflict with both requests held continuously
      glog.delete();
      mode = 1;
      i_req = 1'b1; i_addr = 32'h5;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h9;
      for (int n = 0; n < 40 && glog.size() < 4; n++) tick();
      mode = 0;
      repeat (3 * (LAT + 2) + 2) tick();
      chk("conflict_grants", {63'h0, glog.size() >= 4}, 64'h1);
`ifdef CORE_MEM_ARB_RR_EN
      exp_order = 4'b1010;
`else
      exp_order = 4'b1111;
`endif
      chk("conflict_order", {60'h0, glog[0], glog[1], glog[2], glog[3]}, {60'h0, exp_order});

      // Single fetch
      i_req = 1'b1; i_addr = 32'h10; samp = cyc + 1; i_val_cyc = -1;
      repeat (LAT + 4) tick();
      chk("fetch_latency", 64'(i_val_cyc - samp), 64'(LAT + 1));
      chk("fetch_rdata", {32'h0, I_RDATA}, 64'h0050_0093);

      // Store
      we_cnt = 0;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
      repeat (LAT + 4) tick();
      chk("store_we_cycles", 64'(we_cnt), 64'h1);
      chk("store_mem", {32'h0, mem[64]}, 64'hDEAD_BEEF);
      chk("store_rdata", {32'h0, D_RDATA}, 64'h0);

      // Back-to-back loads
      dvals.delete();
      mode = 1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3; samp = cyc + 1;
      repeat (3 * (LAT + 2)) tick();
      mode = 0;
      repeat (2 * (LAT + 2)) tick();
      chk("b2b_count", {63'h0, dvals.size() >= 3}, 64'h1);
      chk("b2b_first", 64'(dvals[0] - samp), 64'(LAT + 1));
      chk("b2b_gap1", 64'(dvals[1] - dvals[0]), 64'(LAT + 2));
      chk("b2b_gap2", 64'(dvals[2] - dvals[1]), 64'(LAT + 2));

      // Reset during WAIT
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("midrst_m_addr", {32'h0, M_ADDR}, 64'h0);
      chk("midrst_rdata", {I_RDATA, D_RDATA}, 64'h0);
      rst = 1'b0;
      dvals.delete();
      repeat (LAT + 4) tick();
      chk("midrst_no_valid", 64'(dvals.size()), 64'h0);
      i_req = 1'b1; i_addr = 32'h10;
      repeat (LAT + 4) tick();
      chk("midrst_recover", {32'h0, I_RDATA}, 64'h0050_0093);

      // Idle bus
      strobe_cnt = 0;
      repeat (20) tick();
      chk("idle_strobes", 64'(strobe_cnt), 64'h0);

      // Randomized traffic
      mode = 2;
      repeat (400) tick();
      mode = 0;
      repeat (4 * (LAT + 2)) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
